// File: rtl/wbm_req_engine.sv
// wbm_req_engine: single-outstanding pipelined Wishbone master.
// Turns one valid/ready request into one Wishbone cycle and returns the
// outcome (read data, bus error or timeout) on a valid/ready response port.
module wbm_req_engine #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADR_W          = 28
) (
    input  logic             sys_clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [31:0]      req_dat,
    input  logic [3:0]       req_sel,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_timeout,

    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic             wbm_stb_o,
    output logic             wbm_cyc_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_stall_i,
    input  logic             wbm_err_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Last count value before the transaction is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] to_cnt;
    logic        busy;
    logic        term;
    logic        timed_out;

    // Termination only counts while the cycle is open and, in ISSUE, only
    // once the slave has taken the strobe; an ack on the final count beats
    // the timeout.
    always_comb begin
        busy      = (state == S_ISSUE) || (state == S_WAIT);
        term      = wbm_cyc_o && (wbm_ack_i || wbm_err_i) &&
                    (((state == S_ISSUE) && !wbm_stall_i) || (state == S_WAIT));
        timed_out = busy && !term && (to_cnt == TO_LAST);
    end

    assign req_ready = rst_n && (state == S_IDLE);

    // Main controller: request capture, Wishbone handshake, timeout, response hold.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            to_cnt      <= 16'h0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= 4'h0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (busy) begin
                to_cnt <= to_cnt + 16'h1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wbm_adr_o <= req_adr;
                        wbm_dat_o <= req_dat;
                        wbm_we_o  <= req_we;
                        wbm_sel_o <= req_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        to_cnt    <= 16'h0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (term) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= 4'h0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= wbm_err_i;
                        rsp_timeout <= 1'b0;
                        rsp_dat     <= (wbm_err_i || wbm_we_o) ? 32'h0 : wbm_dat_i;
                        state       <= S_RESP;
                    end else if (timed_out) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= 4'h0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_dat     <= 32'h0;
                        state       <= S_RESP;
                    end else if ((state == S_ISSUE) && !wbm_stall_i) begin
                        wbm_stb_o <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_req_engine.sv
// tb_wbm_req_engine: directed bench for wbm_req_engine with a hand-driven slave.
`timescale 1ns/1ps
module tb_wbm_req_engine;

    localparam int ADR_W = 28;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_we;
    logic             req_ready;
    logic [ADR_W-1:0] req_adr;
    logic [31:0]      req_dat;
    logic [3:0]       req_sel;
    logic             rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0]      rsp_dat;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [31:0]      wbm_dat_o, wbm_dat_i;
    logic             wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic [3:0]       wbm_sel_o;
    logic             wbm_ack_i, wbm_stall_i, wbm_err_i;

    int n_vec = 0;
    int n_err = 0;

    wbm_req_engine #(.TIMEOUT_CYCLES(8), .ADR_W(ADR_W)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_dat     (req_dat),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_stall_i (wbm_stall_i),
        .wbm_err_i   (wbm_err_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [ADR_W-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        req_sel   = sel;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '1;
        req_dat   = 32'hFFFF_FFFF;
        req_sel   = 4'h0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("release_valid", rsp_valid, 1'b0);
        chk("release_err", rsp_err, 1'b0);
        chk("release_ready", req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
        req_dat = 32'h0; req_sel = 4'h0; rsp_ready = 1'b0;
        wbm_dat_i = 32'h0; wbm_ack_i = 1'b0; wbm_stall_i = 1'b0; wbm_err_i = 1'b0;
        step();
        step();
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", req_ready, 1'b1);

        // Read, zero-stall slave acking one cycle after the strobe.
        issue(1'b0, 28'h0000100, 32'h0, 4'hF);
        chk("rd_stb", wbm_stb_o, 1'b1);
        chk("rd_cyc", wbm_cyc_o, 1'b1);
        chk("rd_adr", wbm_adr_o, 32'h0000100);
        chk("rd_we", wbm_we_o, 1'b0);
        chk("rd_sel", wbm_sel_o, 4'hF);
        chk("rd_ready_busy", req_ready, 1'b0);
        step();
        chk("rd_stb_one", wbm_stb_o, 1'b0);
        chk("rd_cyc_wait", wbm_cyc_o, 1'b1);
        chk("rd_novalid", rsp_valid, 1'b0);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFEF00D;
        step();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'hDEADBEEF;
        chk("rd_valid", rsp_valid, 1'b1);
        chk("rd_dat", rsp_dat, 32'hCAFEF00D);
        chk("rd_err", rsp_err, 1'b0);
        chk("rd_cyc_drop", wbm_cyc_o, 1'b0);
        chk("rd_sel_idle", wbm_sel_o, 4'h0);
        release_rsp();

        // Write with the slave stalling for five cycles.
        wbm_stall_i = 1'b1;
        issue(1'b1, 28'h0ABCDEF, 32'h12345678, 4'hF);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            chk("wr_stb_held", wbm_stb_o, 1'b1);
            chk("wr_adr_held", wbm_adr_o, 32'h0ABCDEF);
            chk("wr_dat_held", wbm_dat_o, 32'h12345678);
            chk("wr_we_held", wbm_we_o, 1'b1);
        end
        wbm_stall_i = 1'b0;
        step();
        chk("wr_stb_drop", wbm_stb_o, 1'b0);
        chk("wr_cyc_wait", wbm_cyc_o, 1'b1);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h55AA55AA;
        step();
        wbm_ack_i = 1'b0;
        chk("wr_valid", rsp_valid, 1'b1);
        chk("wr_dat_zero", rsp_dat, 32'h0);
        chk("wr_err", rsp_err, 1'b0);
        chk("wr_wbdat_keep", wbm_dat_o, 32'h12345678);
        release_rsp();

        // Error and ack together in the strobe-accept cycle.
        issue(1'b0, 28'h0000200, 32'h0, 4'h3);
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h11111111;
        step();
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        chk("err_valid", rsp_valid, 1'b1);
        chk("err_err", rsp_err, 1'b1);
        chk("err_to", rsp_timeout, 1'b0);
        chk("err_dat", rsp_dat, 32'h0);
        chk("err_cyc", wbm_cyc_o, 1'b0);
        release_rsp();

        // Timeout: silent slave, cyc drops eight edges after the strobe rose.
        issue(1'b0, 28'h0000300, 32'h0, 4'hF);
        chk("to_stb", wbm_stb_o, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_cyc_held", wbm_cyc_o, 1'b1);
            chk("to_novalid", rsp_valid, 1'b0);
        end
        step();
        chk("to_cyc_drop", wbm_cyc_o, 1'b0);
        chk("to_valid", rsp_valid, 1'b1);
        chk("to_err", rsp_err, 1'b1);
        chk("to_flag", rsp_timeout, 1'b1);
        chk("to_dat", rsp_dat, 32'h0);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFFFFFF;
        step();
        wbm_ack_i = 1'b0;
        chk("to_late_dat", rsp_dat, 32'h0);
        chk("to_late_flag", rsp_timeout, 1'b1);
        chk("to_late_valid", rsp_valid, 1'b1);
        release_rsp();
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk("idle_ack_valid", rsp_valid, 1'b0);
        chk("idle_ack_cyc", wbm_cyc_o, 1'b0);

        // Response back-pressure with a pending request held at the input.
        issue(1'b0, 28'h0000400, 32'h0, 4'hF);
        step();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5A5A5;
        step();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        req_valid = 1'b1; req_adr = 28'h0000500;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_dat", rsp_dat, 32'hA5A5A5A5);
            chk("bp_ready", req_ready, 1'b0);
            chk("bp_cyc", wbm_cyc_o, 1'b0);
            step();
        end
        req_valid = 1'b0;
        release_rsp();

        // Reset while waiting for the ack: transaction vanishes.
        issue(1'b0, 28'h0000600, 32'h0, 4'hF);
        step();
        chk("rw_wait_cyc", wbm_cyc_o, 1'b1);
        chk("rw_wait_stb", wbm_stb_o, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rw_cyc", wbm_cyc_o, 1'b0);
        chk("rw_stb", wbm_stb_o, 1'b0);
        chk("rw_valid", rsp_valid, 1'b0);
        chk("rw_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h77777777;
        step();
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rw_no_rsp", rsp_valid, 1'b0);
            chk("rw_no_cyc", wbm_cyc_o, 1'b0);
            step();
        end
        chk("rw_ready_back", req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wbm_req_engine.md
Name: wbm_req_engine

Overview:
- Single-outstanding 32-bit pipelined Wishbone master engine.
- Converts a simple valid/ready request/response interface into a Wishbone transaction on the crossbar master port.
- Used by a virtual-socket core (e.g. the J1B I/O bus) to drive its wbm_* port, which is currently tied off.
- Includes a bus timeout so a dead slave cannot hang the requester.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles from strobe assertion before the transaction is aborted. Legal range 2..65535.
- ADR_W, 28: Wishbone word-address width.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  engine can accept a request
- req_we  input  1  1 = write, 0 = read
- req_adr  input  ADR_W  word address
- req_dat  input  32  write data
- req_sel  input  4  byte selects
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes the response
- rsp_dat  output  32  read data; 0 for writes and errors
- rsp_err  output  1  bus error or timeout
- rsp_timeout  output  1  error was caused by timeout
- wbm_adr_o  output  ADR_W  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_dat_i  input  32  Wishbone read data
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte selects
- wbm_stb_o  output  1  Wishbone strobe
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_stall_i  input  1  Wishbone stall
- wbm_err_i  input  1  Wishbone error

Behaviour:
- Reset (rst_n=0 sampled on a rising edge):
  - State goes to IDLE.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0.
  - rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
  - req_ready=0 while rst_n=0.
- Reset mid-transaction: cyc/stb drop at that edge; the pending response is discarded, with no rsp_valid afterwards. Any late ack arriving after reset is ignored in IDLE.
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state); all Wishbone outputs inactive.
  - On req_valid&&req_ready: register adr/dat/we/sel onto wbm_* outputs, set cyc=stb=1, clear the counter, go to ISSUE.
  - The request is captured in a single cycle; req_* may change afterwards.
- ISSUE:
  - cyc=1, stb=1, address, data, we and sel are held stable.
  - Stays in ISSUE while wbm_stall_i=1.
  - When wbm_stall_i=0, the strobe is accepted: stb=0 next cycle, go to WAIT.
  - If ack or err arrives in the same cycle the strobe is accepted, terminate directly (see termination).
- WAIT: cyc=1, stb=0; waits for wbm_ack_i or wbm_err_i.
- Termination, in ISSUE-accept or WAIT:
  - On ack or err: cyc=0 next cycle, go to RESP, rsp_valid=1.
  - Read with ack: rsp_dat=wbm_dat_i sampled in the ack cycle. Write: rsp_dat=0.
  - err (alone or with ack): rsp_err=1, rsp_dat=0; err wins over ack.
  - ack/err are ignored whenever cyc=0.
- Timeout:
  - The counter increments every cycle in ISSUE and WAIT.
  - If it reaches TIMEOUT_CYCLES-1 with no ack/err, then next cycle: cyc=stb=0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_dat=0.
  - An ack in that same final cycle wins over the timeout.
- RESP:
  - rsp_* held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready: rsp_valid=0, rsp_err=0, rsp_timeout=0, go to IDLE.
  - req_ready=0 in RESP, so no request/response overlap.
- Latency:
  - Request accepted at edge T → stb high during cycle T+1.
  - Zero-stall slave acking during cycle T+2 → rsp_valid high in cycle T+3.
  - Minimum back-to-back rate: one transaction per 4 cycles.
- wbm_sel_o and wbm_we_o are driven only while cyc=1 and are 0 otherwise. wbm_adr_o and wbm_dat_o hold their last value.
- Read data is never taken from a cycle without ack.

Test Plan:
- Read, no stall: req adr=0x0000100 we=0; slave acks one cycle after stb with dat=0xCAFEF00D → stb high exactly 1 cycle, rsp_valid 3 cycles after accept, rsp_dat=0xCAFEF00D, rsp_err=0.
- Write under stall: we=1 dat=0x12345678 sel=0xF; stall held 5 cycles → stb high 6 cycles with adr/dat stable; ack → rsp_dat=0, rsp_err=0.
- Bus error: slave asserts err and ack together → rsp_err=1, rsp_timeout=0, rsp_dat=0.
- Timeout: TIMEOUT_CYCLES=8, slave never responds → cyc drops 8 cycles after stb rises, rsp_err=1, rsp_timeout=1; a late ack afterwards produces no effect.
- Back-pressure and reset: rsp_ready held low 10 cycles → rsp_* stable and req_ready=0; assert rst_n=0 while in WAIT → cyc=stb=rsp_valid=0 next edge, and no response after release.
